// File: rtl/cpu_mem_pkg.sv
// Shared types and constants for the cache-controller / DataMemory path.
package cpu_mem_pkg;

  // Arbiter FSM states.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } arb_state_t;

  // Requester port identifiers.
  localparam logic PORT_ICACHE = 1'b0;
  localparam logic PORT_DCACHE = 1'b1;

  // Default widths shared with the cache controllers and DataMemory.
  localparam int DEF_ADDR_W = 32;
  localparam int DEF_DATA_W = 256;

endpackage

// File: rtl/arb_rr_pick.sv
// Two-port round-robin pick: a lone requester wins, a tie goes to the
// port that was not granted last.
module arb_rr_pick
  import cpu_mem_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last_grant,
  output logic       grant_valid,
  output logic       grant_id
);

  // Decode the request pair into a grant.
  always_comb begin
    grant_valid = |req;
    grant_id    = PORT_ICACHE;
    case (req)
      2'b01:   grant_id = PORT_ICACHE;
      2'b10:   grant_id = PORT_DCACHE;
      2'b11:   grant_id = ~last_grant;
      default: grant_id = PORT_ICACHE;
    endcase
  end

endmodule

// File: rtl/memory_arbiter.sv
// Shares the single DataMemory port between the I-cache (port 0) and the
// D-cache (port 1) controllers, one transaction at a time, with a sticky
// watchdog on a missing memory acknowledge.
module memory_arbiter
  import cpu_mem_pkg::*;
#(
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int DATA_W  = DEF_DATA_W,
  parameter int TIMEOUT = 64
) (
  input  logic              clock_i,
  input  logic              flush_i,
  input  logic              req0_enable_i,
  input  logic              req0_write_i,
  input  logic [ADDR_W-1:0] req0_addr_i,
  input  logic [DATA_W-1:0] req0_data_i,
  output logic              req0_ack_o,
  output logic [DATA_W-1:0] req0_data_o,
  input  logic              req1_enable_i,
  input  logic              req1_write_i,
  input  logic [ADDR_W-1:0] req1_addr_i,
  input  logic [DATA_W-1:0] req1_data_i,
  output logic              req1_ack_o,
  output logic [DATA_W-1:0] req1_data_o,
  output logic              memory_enable_o,
  output logic              memory_write_o,
  output logic [ADDR_W-1:0] memory_addr_o,
  output logic [DATA_W-1:0] memory_data_o,
  input  logic              memory_ack_i,
  input  logic [DATA_W-1:0] memory_data_i,
  output logic              busy_o,
  output logic              error_o
);

  localparam int              WD_W   = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [WD_W-1:0] WD_MAX = WD_W'(TIMEOUT - 1);

  arb_state_t        state_reg, state_next;
  logic              owner_reg, owner_next;
  logic              last_grant_reg, last_grant_next;
  logic [WD_W-1:0]   wd_cnt_reg, wd_cnt_next;
  logic              error_reg, error_next;
  logic              mem_en_reg, mem_en_next;
  logic              mem_wr_reg, mem_wr_next;
  logic [ADDR_W-1:0] mem_addr_reg, mem_addr_next;
  logic [DATA_W-1:0] mem_data_reg, mem_data_next;

  logic grant_valid;
  logic grant_id;
  logic ack_active;

  arb_rr_pick u_pick (
    .req         ({req1_enable_i, req0_enable_i}),
    .last_grant  (last_grant_reg),
    .grant_valid (grant_valid),
    .grant_id    (grant_id)
  );

  // State and output registers; flush wins over everything, including BUSY.
  always_ff @(posedge clock_i) begin
    if (flush_i) begin
      state_reg      <= IDLE;
      owner_reg      <= PORT_ICACHE;
      last_grant_reg <= PORT_DCACHE;
      wd_cnt_reg     <= '0;
      error_reg      <= 1'b0;
      mem_en_reg     <= 1'b0;
      mem_wr_reg     <= 1'b0;
      mem_addr_reg   <= '0;
      mem_data_reg   <= '0;
    end else begin
      state_reg      <= state_next;
      owner_reg      <= owner_next;
      last_grant_reg <= last_grant_next;
      wd_cnt_reg     <= wd_cnt_next;
      error_reg      <= error_next;
      mem_en_reg     <= mem_en_next;
      mem_wr_reg     <= mem_wr_next;
      mem_addr_reg   <= mem_addr_next;
      mem_data_reg   <= mem_data_next;
    end
  end

  // Next-state logic: grant in IDLE, wait for ack in BUSY, one turnaround in DONE.
  always_comb begin
    state_next      = state_reg;
    owner_next      = owner_reg;
    last_grant_next = last_grant_reg;
    wd_cnt_next     = wd_cnt_reg;
    error_next      = error_reg;
    mem_en_next     = mem_en_reg;
    mem_wr_next     = mem_wr_reg;
    mem_addr_next   = mem_addr_reg;
    mem_data_next   = mem_data_reg;
    case (state_reg)
      IDLE: begin
        if (grant_valid) begin
          owner_next    = grant_id;
          mem_en_next   = 1'b1;
          mem_wr_next   = grant_id ? req1_write_i : req0_write_i;
          mem_addr_next = grant_id ? req1_addr_i  : req0_addr_i;
          mem_data_next = grant_id ? req1_data_i  : req0_data_i;
          wd_cnt_next   = '0;
          state_next    = BUSY;
        end
      end
      BUSY: begin
        if (memory_ack_i) begin
          mem_en_next     = 1'b0;
          last_grant_next = owner_reg;
          wd_cnt_next     = '0;
          state_next      = DONE;
        end else if (wd_cnt_reg == WD_MAX) begin
          // Stay in BUSY: the flag is only a report, not an abort.
          error_next = 1'b1;
        end else begin
          wd_cnt_next = wd_cnt_reg + 1'b1;
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Route the memory acknowledge and read data to the owning port only.
  always_comb begin
    ack_active  = (state_reg == BUSY) && memory_ack_i;
    req0_ack_o  = ack_active && (owner_reg == PORT_ICACHE);
    req1_ack_o  = ack_active && (owner_reg == PORT_DCACHE);
    req0_data_o = req0_ack_o ? memory_data_i : '0;
    req1_data_o = req1_ack_o ? memory_data_i : '0;
  end

  assign memory_enable_o = mem_en_reg;
  assign memory_write_o  = mem_wr_reg;
  assign memory_addr_o   = mem_addr_reg;
  assign memory_data_o   = mem_data_reg;
  assign busy_o          = (state_reg != IDLE);
  assign error_o         = error_reg;

endmodule

// File: tb/tb_memory_arbiter.sv
// Self-checking bench for memory_arbiter: directed scenarios plus a random
// transaction phase checked against a transaction-level reference model.
module tb_memory_arbiter;

  localparam int AW = 32;
  localparam int DW = 256;
  localparam int TO = 12;

  logic          clock = 1'b0;
  logic          flush;
  logic          r0_en, r0_wr, r1_en, r1_wr;
  logic [AW-1:0] r0_addr, r1_addr;
  logic [DW-1:0] r0_data, r1_data;
  logic          ack0, ack1;
  logic [DW-1:0] rd0, rd1;
  logic          mem_en, mem_wr, mem_ack;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, mem_rdata;
  logic          busy, error;

  always #5 clock = ~clock;

  memory_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
    .clock_i         (clock),
    .flush_i         (flush),
    .req0_enable_i   (r0_en),
    .req0_write_i    (r0_wr),
    .req0_addr_i     (r0_addr),
    .req0_data_i     (r0_data),
    .req0_ack_o      (ack0),
    .req0_data_o     (rd0),
    .req1_enable_i   (r1_en),
    .req1_write_i    (r1_wr),
    .req1_addr_i     (r1_addr),
    .req1_data_i     (r1_data),
    .req1_ack_o      (ack1),
    .req1_data_o     (rd1),
    .memory_enable_o (mem_en),
    .memory_write_o  (mem_wr),
    .memory_addr_o   (mem_addr),
    .memory_data_o   (mem_wdata),
    .memory_ack_i    (mem_ack),
    .memory_data_i   (mem_rdata),
    .busy_o          (busy),
    .error_o         (error)
  );

  int vectors     = 0;
  int miscompares = 0;

  // Reference model state: who won the last completed transaction, and memory contents.
  bit            last_grant;
  logic [DW-1:0] mem_model [logic [AW-1:0]];

  function automatic logic [DW-1:0] rand_line();
    logic [DW-1:0] r;
    for (int i = 0; i < DW / 32; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check_no_ack(input string tag);
    check({tag, "_ack0"}, ack0, 0);
    check({tag, "_ack1"}, ack1, 0);
    check({tag, "_rd0"}, rd0, 0);
    check({tag, "_rd1"}, rd1, 0);
  endtask

  task automatic do_flush();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    last_grant = 1'b1;
  endtask

  // One complete transaction. Call in IDLE with request inputs already set;
  // w = number of BUSY cycles before the ack cycle.
  task automatic txn(input int w, input bit mutate, input bit drop);
    bit            p;
    logic          e_wr;
    logic [AW-1:0] e_addr;
    logic [DW-1:0] e_data, rdata;
    p      = (r0_en && r1_en) ? ~last_grant : r1_en;
    e_wr   = p ? r1_wr : r0_wr;
    e_addr = p ? r1_addr : r0_addr;
    e_data = p ? r1_data : r0_data;
    if (e_wr) begin
      mem_model[e_addr] = e_data;
      rdata = rand_line();
    end else begin
      if (!mem_model.exists(e_addr)) mem_model[e_addr] = rand_line();
      rdata = mem_model[e_addr];
    end
    tick();
    check("grant_en", mem_en, 1);
    check("grant_busy", busy, 1);
    check("grant_wr", mem_wr, e_wr);
    check("grant_addr", mem_addr, e_addr);
    check("grant_data", mem_wdata, e_data);
    for (int j = 0; j < w; j++) begin
      if (mutate) begin
        r0_addr = $urandom; r1_addr = $urandom;
        r0_wr = 1'($urandom); r1_wr = 1'($urandom);
        r0_data = rand_line(); r1_data = rand_line();
      end
      if (drop) begin
        if (p) r1_en = 1'b0; else r0_en = 1'b0;
      end
      mem_rdata = rand_line();
      #1;
      check_no_ack("wait");
      tick();
      check("hold_en", mem_en, 1);
      check("hold_wr", mem_wr, e_wr);
      check("hold_addr", mem_addr, e_addr);
      check("hold_data", mem_wdata, e_data);
    end
    mem_ack = 1'b1;
    mem_rdata = rdata;
    #1;
    check("ack0", ack0, p == 1'b0);
    check("ack1", ack1, p == 1'b1);
    check("rd0", rd0, p ? '0 : rdata);
    check("rd1", rd1, p ? rdata : '0);
    tick();
    mem_ack = 1'b0;
    mem_rdata = rand_line();
    last_grant = p;
    #1;
    check("done_en", mem_en, 0);
    check("done_busy", busy, 1);
    check("done_err", error, 0);
    check_no_ack("done");
    tick();
    check("idle_busy", busy, 0);
    check("idle_en", mem_en, 0);
    check_no_ack("idle");
  endtask

  initial begin
    flush = 1'b1;
    r0_en = 0; r0_wr = 0; r0_addr = '0; r0_data = '0;
    r1_en = 0; r1_wr = 0; r1_addr = '0; r1_data = '0;
    mem_ack = 0; mem_rdata = '0;
    tick();
    do_flush();

    // Reset state.
    check("rst_busy", busy, 0);
    check("rst_err", error, 0);
    check("rst_en", mem_en, 0);
    check("rst_wr", mem_wr, 0);
    check("rst_addr", mem_addr, 0);
    check("rst_data", mem_wdata, 0);
    check_no_ack("rst");

    // Single read with a slow memory.
    mem_model[32'h0000_0400] = {32{8'hA5}};
    r0_en = 1; r0_wr = 0; r0_addr = 32'h0000_0400;
    txn(10, 0, 1);

    // Tie right after reset: port 0 first, then port 1.
    do_flush();
    r0_en = 1; r0_wr = 0; r0_addr = 32'h0000_0040; r0_data = rand_line();
    r1_en = 1; r1_wr = 1; r1_addr = 32'h0000_0080; r1_data = rand_line();
    txn(2, 0, 0);
    txn(1, 0, 0);

    // Fairness: both hold enable for six transactions.
    r1_wr = 0;
    for (int i = 0; i < 6; i++) txn(0, 0, 0);

    // Write pass-through while the requester changes its address.
    r0_en = 0;
    r1_en = 1; r1_wr = 1; r1_addr = 32'h0000_1000; r1_data = {8{32'h1234_5678}};
    tick();
    r1_en = 0;
    #1;
    r1_en = 1;
    txn(0, 0, 0);
    r1_en = 1; r1_wr = 1; r1_addr = 32'h0000_1000; r1_data = {8{32'h1234_5678}};
    r0_en = 0;
    begin
      tick();
      check("wp_wr", mem_wr, 1);
      check("wp_addr", mem_addr, 32'h0000_1000);
      r1_addr = 32'h0000_2000;
      r1_en = 0;
      for (int j = 0; j < 3; j++) begin
        tick();
        check("wp_hold_addr", mem_addr, 32'h0000_1000);
        check("wp_hold_wr", mem_wr, 1);
      end
      mem_ack = 1'b1;
      #1;
      check("wp_ack1", ack1, 1);
      check("wp_ack0", ack0, 0);
      tick();
      mem_ack = 1'b0;
      last_grant = 1'b1;
      tick();
      check("wp_idle", busy, 0);
    end

    // Watchdog boundary: ack in the last allowed BUSY cycle leaves error clear.
    r0_en = 1; r0_wr = 0; r0_addr = 32'h0000_0100;
    txn(TO - 1, 0, 1);

    // Flush mid-transaction, then a stray ack.
    r0_en = 1; r0_addr = 32'h0000_0200; r1_en = 0;
    tick();
    r0_en = 0;
    check("mid_en", mem_en, 1);
    tick();
    tick();
    do_flush();
    mem_ack = 1'b1;
    mem_rdata = rand_line();
    #1;
    check("mid_en_after", mem_en, 0);
    check("mid_busy", busy, 0);
    check("mid_addr", mem_addr, 0);
    check_no_ack("mid_stray");
    tick();
    check("mid_stay_idle", busy, 0);
    mem_ack = 1'b0;
    r0_en = 1; r0_wr = 0; r0_addr = 32'h0000_0300;
    txn(1, 0, 1);

    // Randomized transactions.
    for (int i = 0; i < 40; i++) begin
      r0_en = 1'($urandom);
      r1_en = r0_en ? 1'($urandom) : 1'b1;
      r0_wr = 1'($urandom); r1_wr = 1'($urandom);
      r0_addr = AW'($urandom_range(0, 15)) << 5;
      r1_addr = AW'($urandom_range(0, 15)) << 5;
      r0_data = rand_line(); r1_data = rand_line();
      txn($urandom_range(0, 5), 1'($urandom), 1'($urandom));
    end

    // Watchdog: memory never acks.
    r0_en = 0; r1_en = 1; r1_wr = 0; r1_addr = 32'h0000_0500;
    tick();
    r1_en = 0;
    for (int j = 0; j < TO; j++) begin
      #1;
      check("wd_err_clear", error, 0);
      tick();
    end
    check("wd_err_set", error, 1);
    check("wd_busy", busy, 1);
    for (int j = 0; j < 4; j++) tick();
    check("wd_err_sticky", error, 1);
    check("wd_busy_sticky", busy, 1);
    do_flush();
    #1;
    check("wd_err_flush", error, 0);
    check("wd_busy_flush", busy, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
